io_req_responder: RTL and testbench

Responder end of the scheduler's I/O fetch interface. Accepts read-address requests from the compute scheduler's buffer-fill logic, issues them to a fixed-latency synchronous memory port, and returns the read data in request order through a valid/ready response channel. A credit counter bounds outstanding requests so returned memory data is never dropped, even under response back-pressure.

---
 rtl/io_pkg.sv | 14 +
 rtl/io_rsp_fifo.sv | 50 +++++
 rtl/io_req_responder.sv | 113 +++++++++++
 tb/tb_io_req_responder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared I/O definitions for the scheduler fetch path: default widths and the
// response word layout used by the responder and compute_scheduler.
package io_pkg;

    localparam int IO_DATA_WIDTH_DEF = 32;
    localparam int IO_ADDR_WIDTH_DEF = 16;

    // One response word: error flag above the read data.
    typedef struct packed {
        logic                         err;
        logic [IO_DATA_WIDTH_DEF-1:0] data;
    } io_rsp_t;

endpackage

// File: rtl/io_rsp_fifo.sv
// Generic synchronous show-ahead FIFO. The head entry is visible on data_o
// whenever empty_o is low; pointers carry an extra wrap bit for full/empty.
module io_rsp_fifo
    import io_pkg::*;
#(
    parameter int WIDTH = $bits(io_rsp_t),
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign count_o = wr_q - rd_q;
    assign data_o  = mem_q[rd_q[AW-1:0]];

    // Pointer update; pops on an empty FIFO are ignored.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + 1'b1;
            if (pop_i && !empty_o) rd_q <= rd_q + 1'b1;
        end
    end

    // Storage array; contents need no reset because the pointers gate them.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q[AW-1:0]] <= data_i;
    end

    // Callers must never push into a full FIFO.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rstn) !(push_i && full_o));

endmodule

// File: rtl/io_req_responder.sv
// Responder for the scheduler's I/O fetch interface: issues accepted read
// requests to a fixed-latency memory port and returns the data in request
// order. A credit counter caps outstanding requests at the response FIFO
// depth so memory data arriving under back-pressure always has a slot.
module io_req_responder
    import io_pkg::*;
#(
    parameter int     IO_DATA_WIDTH  = IO_DATA_WIDTH_DEF,
    parameter int     IO_ADDR_WIDTH  = IO_ADDR_WIDTH_DEF,
    parameter int     MEM_LATENCY    = 2,
    parameter int     RSP_FIFO_DEPTH = 4,
    parameter longint ADDR_LIMIT     = 64'd1 << IO_ADDR_WIDTH
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [IO_ADDR_WIDTH-1:0] req_addr,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IO_DATA_WIDTH-1:0] rsp_data,
    output logic                     rsp_err,
    output logic                     mem_rd_en,
    output logic [IO_ADDR_WIDTH-1:0] mem_addr,
    input  logic [IO_DATA_WIDTH-1:0] mem_rd_data
);

    localparam int CW = $clog2(RSP_FIFO_DEPTH) + 1;

    logic [CW-1:0]          outstanding_q;
    logic [CW-1:0]          outstanding_d;
    logic [MEM_LATENCY-1:0] vld_q;
    logic [MEM_LATENCY-1:0] err_q;

    logic                   accept;
    logic                   addr_err;
    logic                   push;
    logic                   pop;
    logic                   last_err;
    logic [IO_DATA_WIDTH-1:0] push_word;
    logic [IO_DATA_WIDTH:0] push_data;
    logic [IO_DATA_WIDTH:0] head_data;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CW-1:0]          fifo_count;

    // Request side: credits come only from registered state.
    assign req_ready = rstn && (outstanding_q < CW'(RSP_FIFO_DEPTH));
    assign accept    = req_valid && req_ready;
    assign addr_err  = (64'(req_addr) >= 64'(ADDR_LIMIT));
    assign mem_rd_en = accept && !addr_err;
    assign mem_addr  = mem_rd_en ? req_addr : '0;

    // Last tracking stage lines up with the memory's read data.
    assign push      = vld_q[MEM_LATENCY-1];
    assign last_err  = err_q[MEM_LATENCY-1];
    assign push_word = last_err ? '0 : mem_rd_data;
    assign push_data = {last_err, push_word};

    // Response side: everything is forced quiet while reset is held.
    assign rsp_valid = rstn && !fifo_empty;
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_err   = rsp_valid && head_data[IO_DATA_WIDTH];
    assign rsp_data  = rsp_valid ? head_data[IO_DATA_WIDTH-1:0] : '0;

    // Credit count: accept takes a credit, pop returns one.
    always_comb begin
        outstanding_d = outstanding_q;
        case ({accept, pop})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    // Control state: credit counter and tracking-pipeline valids.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            outstanding_q <= '0;
            vld_q         <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            vld_q[0]      <= accept;
            for (int i = 1; i < MEM_LATENCY; i++) vld_q[i] <= vld_q[i-1];
        end
    end

    // Error flags ride alongside the valids; qualified by vld_q, so no reset.
    always_ff @(posedge clk) begin
        err_q[0] <= addr_err;
        for (int i = 1; i < MEM_LATENCY; i++) err_q[i] <= err_q[i-1];
    end

    io_rsp_fifo #(
        .WIDTH (IO_DATA_WIDTH + 1),
        .DEPTH (RSP_FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (pop),
        .data_o  (head_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Credits always cover everything queued, so the FIFO can never overflow.
    a_credit_covers_fifo: assert property (@(posedge clk) disable iff (!rstn)
        (outstanding_q >= fifo_count) && !(push && fifo_full));

endmodule

// File: tb/tb_io_req_responder.sv
// Directed bench for io_req_responder with a two-cycle memory model
// returning mem[a] = a ^ 32'hA5A5_0000.
module tb_io_req_responder;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic [31:0] mem_rd_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    io_req_responder #(
        .IO_DATA_WIDTH  (32),
        .IO_ADDR_WIDTH  (16),
        .MEM_LATENCY    (2),
        .RSP_FIFO_DEPTH (4),
        .ADDR_LIMIT     (64'h100)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data)
    );

    function automatic logic [31:0] memf(input logic [15:0] a);
        return {16'h0, a} ^ 32'hA5A5_0000;
    endfunction

    // Memory model: data two cycles after the strobe, garbage otherwise.
    logic [31:0] m1, m2;
    always @(posedge clk) begin
        m1 <= mem_rd_en ? memf(mem_addr) : 32'hDEAD_BEEF;
        m2 <= m1;
    end
    assign mem_rd_data = m2;

    // Move to the drive point just after the active edge.
    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; req_valid = 1'b1; req_addr = 16'h0010; rsp_ready = 1'b1;
        adv();
        adv();
        @(negedge clk);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got %b want 0", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %b want 0", rsp_err); end
        checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data got %h want 0", rsp_data); end
        checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL reset_mem_rd_en got %b want 0", mem_rd_en); end
        checks++; if (mem_addr !== 16'h0) begin errors++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
        adv();
        rstn = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_req_ready got %b want 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL post_reset_rsp_valid got %b want 0", rsp_valid); end
    endtask

    task automatic test_single_read();
        adv();
        req_valid = 1'b1; req_addr = 16'h0010; rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (mem_rd_en !== 1'b1) begin errors++; $display("FAIL single_mem_rd_en got %b want 1", mem_rd_en); end
        checks++; if (mem_addr !== 16'h0010) begin errors++; $display("FAIL single_mem_addr got %h want 0010", mem_addr); end
        for (int c = 1; c <= 4; c++) begin
            adv();
            req_valid = 1'b0;
            @(negedge clk);
            if (c == 3) begin
                checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_latency got rsp_valid=%b want 1 at T+3", rsp_valid); end
                checks++; if (rsp_data !== 32'hA5A5_0010) begin errors++; $display("FAIL single_data got %h want a5a50010", rsp_data); end
                checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL single_err got %b want 0", rsp_err); end
            end else begin
                checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_valid_c%0d got %b want 0", c, rsp_valid); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        adv();
        rsp_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) adv();
            req_valid = (c < 8);
            req_addr  = 16'h0020 + 16'(c);
            @(negedge clk);
            if (c < 8) begin
                checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_req_ready_c%0d got %b want 1", c, req_ready); end
            end
            if (rsp_valid === 1'b1 && n < 8) begin
                checks++; if (c != 3 + n) begin errors++; $display("FAIL b2b_timing_rsp%0d got cycle %0d want %0d", n, c, 3 + n); end
                checks++; if (rsp_data !== memf(16'h0020 + 16'(n)) || rsp_err !== 1'b0) begin
                    errors++; $display("FAIL b2b_data_rsp%0d got %h/%b want %h/0", n, rsp_data, rsp_err, memf(16'h0020 + 16'(n)));
                end
                n++;
            end
        end
        req_valid = 1'b0;
        checks++; if (n != 8) begin errors++; $display("FAIL b2b_count got %0d want 8", n); end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        int n = 0;
        adv();
        rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 16'h0040;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) adv();
            req_addr = 16'h0040 + 16'(acc);
            @(negedge clk);
            if (req_valid && req_ready) acc++;
            if (c == 5) begin
                checks++; if (acc != 4) begin errors++; $display("FAIL bp_accepted got %0d want 4", acc); end
            end
        end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %b want 0", req_ready); end
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== memf(16'h0040)) begin
            errors++; $display("FAIL bp_head got %b/%h want 1/%h", rsp_valid, rsp_data, memf(16'h0040));
        end
        // One-cycle pop: ready must not return in the same cycle.
        adv();
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_same_cycle got %b want 0", req_ready); end
        adv();
        rsp_ready = 1'b0; req_addr = 16'h0044;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_next_cycle got %b want 1", req_ready); end
        adv();
        req_valid = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_refull_ready got %b want 0", req_ready); end
        for (int c = 0; c < 20; c++) begin
            adv();
            rsp_ready = 1'b1;
            @(negedge clk);
            if (rsp_valid === 1'b1 && n < 4) begin
                checks++; if (rsp_data !== memf(16'h0041 + 16'(n)) || rsp_err !== 1'b0) begin
                    errors++; $display("FAIL bp_drain_rsp%0d got %h/%b want %h/0", n, rsp_data, rsp_err, memf(16'h0041 + 16'(n)));
                end
                n++;
            end
        end
        checks++; if (n != 4) begin errors++; $display("FAIL bp_drain_count got %0d want 4", n); end
    endtask

    task automatic test_out_of_range();
        logic [15:0] addrs [3];
        logic [31:0] exp_d [3];
        logic        exp_e [3];
        int n = 0;
        addrs[0] = 16'h00FF; addrs[1] = 16'h0100; addrs[2] = 16'h0001;
        exp_d[0] = 32'hA5A5_00FF; exp_d[1] = 32'h0; exp_d[2] = 32'hA5A5_0001;
        exp_e[0] = 1'b0; exp_e[1] = 1'b1; exp_e[2] = 1'b0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            adv();
            req_valid = (c < 3);
            req_addr  = (c < 3) ? addrs[c] : 16'h0;
            @(negedge clk);
            if (c < 3) begin
                checks++; if (mem_rd_en !== ~exp_e[c]) begin errors++; $display("FAIL oor_mem_rd_en_%0d got %b want %b", c, mem_rd_en, ~exp_e[c]); end
            end
            if (rsp_valid === 1'b1 && n < 3) begin
                checks++; if (rsp_data !== exp_d[n] || rsp_err !== exp_e[n]) begin
                    errors++; $display("FAIL oor_rsp%0d got %h/%b want %h/%b", n, rsp_data, rsp_err, exp_d[n], exp_e[n]);
                end
                n++;
            end
        end
        checks++; if (n != 3) begin errors++; $display("FAIL oor_count got %0d want 3", n); end
    endtask

    task automatic test_reset_midflight();
        int stale = 0;
        int acc = 0;
        adv();
        rsp_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) adv();
            req_valid = (c < 3);
            req_addr  = 16'h0050 + 16'(c);
        end
        adv();
        rstn = 1'b0;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            errors++; $display("FAIL midrst_during got valid=%b ready=%b want 0/0", rsp_valid, req_ready);
        end
        adv();
        rstn = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_after got ready=%b valid=%b want 1/0", req_ready, rsp_valid);
        end
        rsp_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            adv();
            @(negedge clk);
            if (rsp_valid !== 1'b0) stale++;
        end
        checks++; if (stale != 0) begin errors++; $display("FAIL midrst_stale got %0d stale cycles want 0", stale); end
        // Full credit budget must be available again.
        rsp_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            adv();
            req_valid = 1'b1; req_addr = 16'h0060 + 16'(acc);
            @(negedge clk);
            if (req_ready) acc++;
        end
        req_valid = 1'b0;
        checks++; if (acc != 4) begin errors++; $display("FAIL midrst_credits got %0d want 4", acc); end
    endtask

    initial begin
        rstn = 1'b0; req_valid = 1'b0; req_addr = 16'h0; rsp_ready = 1'b0;
        test_reset();
        test_single_read();
        test_back_to_back();
        test_backpressure();
        test_out_of_range();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
